// File: rtl/pipe_skid_stage.sv
// Two-entry skid buffer pipeline stage with fully registered valid/ready outputs.
// Optional backpressure statistic counter enabled by defining PIPE_SKID_STALL_CNT_EN.
module pipe_skid_stage #(
    parameter int N = 31
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_valid,
    input  logic [N:0]   in_data,
    output logic         in_ready,
    output logic         out_valid,
    output logic [N:0]   out_data,
    input  logic         out_ready,
    output logic [15:0]  stall_cnt
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_BUSY  = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    state_t       r_state;
    logic [N:0]   r_main;
    logic [N:0]   r_skid;
    logic         r_out_valid;
    logic         r_in_ready;
    logic         w_xfer_in;
    logic         w_xfer_out;

    assign w_xfer_in  = in_valid & r_in_ready;
    assign w_xfer_out = r_out_valid & out_ready;

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_main;

    // Valid/ready are kept as their own flops so neither depends on this cycle's handshake inputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_EMPTY;
            r_main      <= '0;
            r_skid      <= '0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
        end else if (flush) begin
            r_state     <= S_EMPTY;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
        end else begin
            case (r_state)
                S_EMPTY: begin
                    if (w_xfer_in) begin
                        r_main      <= in_data;
                        r_state     <= S_BUSY;
                        r_out_valid <= 1'b1;
                        r_in_ready  <= 1'b1;
                    end
                end
                S_BUSY: begin
                    if (w_xfer_in && w_xfer_out) begin
                        r_main <= in_data;
                    end else if (w_xfer_out) begin
                        r_state     <= S_EMPTY;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end else if (w_xfer_in) begin
                        r_skid     <= in_data;
                        r_state    <= S_FULL;
                        r_in_ready <= 1'b0;
                    end
                end
                S_FULL: begin
                    if (w_xfer_out) begin
                        r_main     <= r_skid;
                        r_state    <= S_BUSY;
                        r_in_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= S_EMPTY;
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                end
            endcase
        end
    end

`ifdef PIPE_SKID_STALL_CNT_EN
    logic [15:0] r_stall_cnt;

    // Saturating count of edges where downstream refused a valid word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cnt <= '0;
        end else if (flush) begin
            r_stall_cnt <= '0;
        end else if (r_out_valid && !out_ready && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`else
    assign stall_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Self-checking bench for pipe_skid_stage: queue-based model compared every cycle plus directed literal checks.
// Long stall-counter saturation run is included only when PIPE_SKID_STALL_CNT_EN is defined.
module tb_pipe_skid_stage;

    localparam int N = 31;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         flush = 1'b0;
    logic         in_valid = 1'b0;
    logic [N:0]   in_data = '0;
    logic         in_ready;
    logic         out_valid;
    logic [N:0]   out_data;
    logic         out_ready = 1'b0;
    logic [15:0]  stall_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    pipe_skid_stage #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: the stage is a FIFO of depth two; output shows the head or the last head.
    logic [N:0]   mq[$];
    logic [N:0]   m_last = '0;
    logic [15:0]  m_cnt = '0;

    always @(negedge rst) begin
        mq.delete();
        m_last = '0;
        m_cnt  = '0;
    end

    always @(posedge clk) begin
        if (rst) begin
            automatic bit xin  = in_valid && (mq.size() < 2);
            automatic bit xout = (mq.size() > 0) && out_ready;
`ifdef PIPE_SKID_STALL_CNT_EN
            if (flush) m_cnt = '0;
            else if ((mq.size() > 0) && !out_ready && (m_cnt != 16'hFFFF)) m_cnt = m_cnt + 16'd1;
`endif
            if (flush) begin
                mq.delete();
            end else begin
                if (xout) void'(mq.pop_front());
                if (xin)  mq.push_back(in_data);
            end
            if (mq.size() > 0) m_last = mq[0];
        end
    end

    always @(posedge clk) begin
        #1;
        chk("model_out_valid", {31'd0, out_valid}, {31'd0, (mq.size() > 0)});
        chk("model_in_ready",  {31'd0, in_ready},  {31'd0, (mq.size() < 2)});
        chk("model_out_data",  out_data, m_last);
        chk("model_stall_cnt", {16'd0, stall_cnt}, {16'd0, m_cnt});
    end

    task automatic cyc(input logic v, input logic [N:0] d, input logic ordy, input logic fl);
        @(negedge clk);
        in_valid  = v;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        @(posedge clk);
        #2;
        $display("txn v=%0d d=%0d ordy=%0d fl=%0d -> ov=%0d od=%0d ir=%0d sc=%0d",
                 v, d, ordy, fl, out_valid, out_data, in_ready, stall_cnt);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog time limit expired");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with a word offered
        rst = 1'b0;
        in_valid = 1'b1;
        in_data = 32'hDEADBEEF;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
        chk("rst_out_data",  out_data, 32'd0);
        chk("rst_stall_cnt", {16'd0, stall_cnt}, 32'd0);
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;

        // Streaming
        for (int i = 1; i <= 4; i++) begin
            cyc(1'b1, i, 1'b1, 1'b0);
            chk("stream_data",  out_data, i);
            chk("stream_valid", {31'd0, out_valid}, 32'd1);
            chk("stream_ready", {31'd0, in_ready},  32'd1);
        end
        cyc(1'b0, 0, 1'b1, 1'b0);
        chk("drain_valid", {31'd0, out_valid}, 32'd0);
        chk("drain_hold",  out_data, 32'd4);

        // Backpressure
        cyc(1'b1, 10, 1'b0, 1'b0);
        cyc(1'b1, 11, 1'b0, 1'b0);
        chk("bp_full_ready", {31'd0, in_ready}, 32'd0);
        chk("bp_full_data",  out_data, 32'd10);
        cyc(1'b1, 12, 1'b0, 1'b0);
        chk("bp_held_data",  out_data, 32'd10);
        cyc(1'b1, 12, 1'b1, 1'b0);
        chk("bp_out1", out_data, 32'd11);
        cyc(1'b1, 12, 1'b1, 1'b0);
        chk("bp_out2", out_data, 32'd12);
        cyc(1'b0, 0, 1'b1, 1'b0);
        chk("bp_empty", {31'd0, out_valid}, 32'd0);

        // Flush from FULL while offering 99
        cyc(1'b1, 10, 1'b0, 1'b0);
        cyc(1'b1, 11, 1'b0, 1'b0);
        cyc(1'b1, 99, 1'b0, 1'b1);
        chk("flush_valid", {31'd0, out_valid}, 32'd0);
        chk("flush_ready", {31'd0, in_ready},  32'd1);
        cyc(1'b0, 0, 1'b1, 1'b0);
        chk("flush_no99", out_data, 32'd10);

        // Asynchronous reset while FULL
        cyc(1'b1, 20, 1'b0, 1'b0);
        cyc(1'b1, 21, 1'b0, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        chk("arst_valid", {31'd0, out_valid}, 32'd0);
        chk("arst_ready", {31'd0, in_ready},  32'd1);
        chk("arst_data",  out_data, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        cyc(1'b1, 5, 1'b1, 1'b0);
        chk("arst_first", out_data, 32'd5);
        cyc(1'b0, 0, 1'b1, 1'b0);

        // Stall counter
        cyc(1'b1, 7, 1'b0, 1'b0);
        repeat (3) cyc(1'b0, 0, 1'b0, 1'b0);
`ifdef PIPE_SKID_STALL_CNT_EN
        chk("stall_3", {16'd0, stall_cnt}, 32'd3);
        repeat (70000) begin
            @(negedge clk);
            in_valid = 1'b0;
            out_ready = 1'b0;
            flush = 1'b0;
        end
        @(posedge clk);
        #2;
        chk("stall_sat", {16'd0, stall_cnt}, 32'hFFFF);
        cyc(1'b0, 0, 1'b0, 1'b1);
        chk("stall_flush", {16'd0, stall_cnt}, 32'd0);
`else
        chk("stall_off", {16'd0, stall_cnt}, 32'd0);
        cyc(1'b0, 0, 1'b0, 1'b1);
`endif
        cyc(1'b0, 0, 1'b1, 1'b0);
        chk("end_empty", {31'd0, out_valid}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
